// File: rtl/step_accumulator.sv
// ----------------------------------------------------------------------------
// step_accumulator
//
// This block sits upstream of the equality Comparator. It captures a stop
// value and a step size when a run starts. While the run is active it adds
// the step to an accumulator on every clock. acc_out feeds CompA and stop_out
// feeds CompB. The Comparator output comes back on comp_match and ends the
// run. The comparator is combinational from this block's registered outputs,
// so a match is judged on the accumulator value held during that cycle. The
// accumulator is therefore never stepped past a matching value.
//
// FSM: IDLE -> RUN -> DONE. A start restarts the block directly from DONE.
// rst is synchronous, active-high, and wins over every input in any state.
//
// Configuration:
//   STEP_ACC_ABORT_EN  When this is defined, an add that carries out of bit
//                      WIDTH-1 is suppressed. In that case the accumulator
//                      keeps its value, ovf is set and the run ends in DONE.
//                      When it is undefined, the add wraps modulo 2^WIDTH,
//                      no carry logic is built and ovf is tied to 0.
//
// Parameters:
//   WIDTH   accumulator / stop value width (matches the Comparator inputs)
//   STEP_W  step operand width, zero-extended to WIDTH before the add
//
// Ports:
//   clk         in   rising-edge clock
//   rst         in   synchronous reset, active-high
//   start       in   begin a run; honoured in IDLE and DONE only
//   pause       in   hold the accumulator while in RUN
//   stop_val    in   stop value, captured on an accepted start
//   step        in   increment, captured on an accepted start
//   comp_match  in   Comparator output (acc_out == stop_out)
//   acc_out     out  registered accumulator -> CompA
//   stop_out    out  registered stop value  -> CompB
//   busy        out  registered, 1 while in RUN
//   done        out  registered, 1 while in DONE
//   ovf         out  registered carry-out abort flag (0 without the macro)
// ----------------------------------------------------------------------------
module step_accumulator #(
    parameter int WIDTH  = 10,
    parameter int STEP_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              pause,
    input  logic [WIDTH-1:0]  stop_val,
    input  logic [STEP_W-1:0] step,
    input  logic              comp_match,
    output logic [WIDTH-1:0]  acc_out,
    output logic [WIDTH-1:0]  stop_out,
    output logic              busy,
    output logic              done,
    output logic              ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t            state;
    state_t            state_next;
    logic [STEP_W-1:0] step_reg;
    logic [STEP_W-1:0] step_next;
    logic [WIDTH-1:0]  acc_next;
    logic [WIDTH-1:0]  stop_next;
    logic [WIDTH-1:0]  step_ext;
    logic [WIDTH-1:0]  sum;

    assign step_ext = WIDTH'(step_reg);

`ifdef STEP_ACC_ABORT_EN
    logic [WIDTH:0] sum_full;
    logic           carry;
    logic           ovf_next;

    // Compute one extra bit so that the carry out of the MSB is visible.
    assign sum_full = {1'b0, acc_out} + {1'b0, step_ext};
    assign sum      = sum_full[WIDTH-1:0];
    assign carry    = sum_full[WIDTH];
`else
    // The result wraps naturally at WIDTH bits.
    assign sum = acc_out + step_ext;
    assign ovf = 1'b0;
`endif

    // Next-state and next-register logic.
    // NOTE: every signal gets a default value before the case statement.
    // Any path that does not assign a signal then holds the registered value
    // instead of inferring a latch.
    always_comb begin
        state_next = state;
        acc_next   = acc_out;
        stop_next  = stop_out;
        step_next  = step_reg;
`ifdef STEP_ACC_ABORT_EN
        ovf_next   = ovf;
`endif

        case (state)
            IDLE, DONE: begin
                if (start) begin
                    stop_next  = stop_val;
                    step_next  = step;
                    acc_next   = '0;
`ifdef STEP_ACC_ABORT_EN
                    ovf_next   = 1'b0;
`endif
                    state_next = RUN;
                end
            end

            RUN: begin
                // Match beats pause, and pause beats stepping.
                // start, stop_val and step are all ignored here.
                if (comp_match) begin
                    state_next = DONE;
                end else if (!pause) begin
`ifdef STEP_ACC_ABORT_EN
                    if (carry) begin
                        ovf_next   = 1'b1;
                        state_next = DONE;
                    end else begin
                        acc_next = sum;
                    end
`else
                    acc_next = sum;
`endif
                end
            end

            default: state_next = IDLE;
        endcase
    end

    // State and output registers.
    // busy and done are decoded from the next state, so they are registered
    // outputs that line up with the state register.
    // NOTE: sequential state uses non-blocking assignments only. This way all
    // registers update together from values sampled before the edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            acc_out  <= '0;
            stop_out <= '0;
            step_reg <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef STEP_ACC_ABORT_EN
            ovf      <= 1'b0;
`endif
        end else begin
            state    <= state_next;
            acc_out  <= acc_next;
            stop_out <= stop_next;
            step_reg <= step_next;
            busy     <= (state_next == RUN);
            done     <= (state_next == DONE);
`ifdef STEP_ACC_ABORT_EN
            ovf      <= ovf_next;
`endif
        end
    end

endmodule

// File: tb/tb_step_accumulator.sv
// ----------------------------------------------------------------------------
// tb_step_accumulator
//
// Directed bench for step_accumulator. It models the downstream equality
// Comparator as a continuous assign. All stimulus is a linear sequence of
// steps in one initial block. Each expected value is hand-computed from the
// intended behaviour. Outputs are sampled 1 time unit after the rising edge.
// ----------------------------------------------------------------------------
module tb_step_accumulator;

    localparam int WIDTH  = 10;
    localparam int STEP_W = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              pause;
    logic [WIDTH-1:0]  stop_val;
    logic [STEP_W-1:0] step;
    logic              comp_match;
    logic [WIDTH-1:0]  acc_out;
    logic [WIDTH-1:0]  stop_out;
    logic              busy;
    logic              done;
    logic              ovf;

    int n_cmp = 0;
    int n_err = 0;
    int j;

    step_accumulator #(.WIDTH(WIDTH), .STEP_W(STEP_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pause      (pause),
        .stop_val   (stop_val),
        .step       (step),
        .comp_match (comp_match),
        .acc_out    (acc_out),
        .stop_out   (stop_out),
        .busy       (busy),
        .done       (done),
        .ovf        (ovf)
    );

    // Downstream Comparator model.
    assign comp_match = (acc_out == stop_out);

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input int obs, input int exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_start(input int sv, input int st);
        start    = 1'b1;
        stop_val = WIDTH'(sv);
        step     = STEP_W'(st);
        tick();
        start    = 1'b0;
    endtask

    // Watchdog so the bench cannot hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; pause = 1'b0; stop_val = '0; step = '0;

        // Reset state after two cycles of rst.
        tick(); tick();
        check("rst_acc",  acc_out,  0);
        check("rst_stop", stop_out, 0);
        check("rst_busy", busy,     0);
        check("rst_done", done,     0);
        check("rst_ovf",  ovf,      0);
        rst = 1'b0;
        tick();
        check("idle_busy", busy, 0);

        // T1: stop 12, step 3 -> 0,3,6,9,12, then done at N+5.
        do_start(12, 3);
        check("t1_acc0",  acc_out,  0);
        check("t1_stop",  stop_out, 12);
        check("t1_busy0", busy,     1);
        check("t1_done0", done,     0);
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("t1_acc%0d", k), acc_out, 3 * k);
            check($sformatf("t1_busy%0d", k), busy, 1);
        end
        tick();
        check("t1_done", done,    1);
        check("t1_busy", busy,    0);
        check("t1_accf", acc_out, 12);
        tick();
        check("t1_hold_acc",  acc_out, 12);
        check("t1_hold_done", done,    1);

        // T2: restart from DONE with stop 0 -> done at N+1, never stepped.
        do_start(0, 5);
        check("t2_busy", busy,    1);
        check("t2_acc0", acc_out, 0);
        tick();
        check("t2_done", done,    1);
        check("t2_acc",  acc_out, 0);
        tick();
        check("t2_acc_hold", acc_out, 0);

        // T3: pause holds the accumulator; a match beats pause.
        do_start(9, 3);
        tick();
        check("t3_acc3", acc_out, 3);
        pause = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check($sformatf("t3_pause%0d", k), acc_out, 3);
            check($sformatf("t3_pbusy%0d", k), busy, 1);
        end
        pause = 1'b0;
        tick();
        check("t3_acc6", acc_out, 6);
        tick();
        check("t3_acc9", acc_out, 9);
        pause = 1'b1;
        tick();
        check("t3_match_over_pause", done, 1);
        check("t3_acc_final",        acc_out, 9);
        pause = 1'b0;

        // T4: a start during RUN is ignored; then rst returns to IDLE.
        do_start(30, 3);
        tick();
        check("t4_acc3", acc_out, 3);
        start = 1'b1; stop_val = 10'd5; step = 4'd1;
        tick();
        start = 1'b0;
        check("t4_acc6_ignore", acc_out,  6);
        check("t4_stop_ignore", stop_out, 30);
        check("t4_busy",        busy,     1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t4_rst_acc",  acc_out,  0);
        check("t4_rst_stop", stop_out, 0);
        check("t4_rst_busy", busy,     0);
        check("t4_rst_done", done,     0);
        tick();
        check("t4_idle_busy", busy, 0);
        check("t4_idle_done", done, 0);

        // A step of 0 with a nonzero stop value never matches.
        do_start(5, 0);
        for (int k = 0; k < 10; k++) tick();
        check("z_busy", busy,    1);
        check("z_acc",  acc_out, 0);
        rst = 1'b1; tick(); rst = 1'b0;
        check("z_rst_busy", busy, 0);

`ifndef STEP_ACC_ABORT_EN
        // T5: stop 2, step 3 wraps 1023 -> 2 and is done at N+343.
        do_start(2, 3);
        j = 0;
        while (!done && j < 400) begin
            tick();
            j++;
            if (j == 341) check("t5_acc1023", acc_out, 1023);
            if (j == 342) check("t5_acc_wrap", acc_out, 2);
        end
        check("t5_done_edge", j,       343);
        check("t5_done",      done,    1);
        check("t5_acc",       acc_out, 2);
        check("t5_ovf",       ovf,     0);
`else
        // T6: stop 10, step 4 carries out at 1020 + 4, so the run aborts.
        do_start(10, 4);
        j = 0;
        while (!done && j < 400) begin
            tick();
            j++;
            if (j == 255) check("t6_acc1020_pre", acc_out, 1020);
        end
        check("t6_done_edge", j,       256);
        check("t6_done",      done,    1);
        check("t6_acc",       acc_out, 1020);
        check("t6_ovf",       ovf,     1);
        tick();
        check("t6_ovf_hold",  ovf,     1);
`endif

        // Restart from DONE with stop 4, step 4 -> ovf clear, done at N+2.
        do_start(4, 4);
        check("rs_ovf",  ovf,     0);
        check("rs_acc0", acc_out, 0);
        check("rs_busy", busy,    1);
        tick();
        check("rs_acc4", acc_out, 4);
        check("rs_done1", done,   0);
        tick();
        check("rs_done", done,    1);
        check("rs_acc",  acc_out, 4);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
